uart_rx_core: RTL

Serial receive engine for the memory-mapped UART. It sits directly upstream of the UART control/register block. It oversamples the asynchronous `rxd` line at 16x the bit rate and deframes 8-bit characters, with optional even or odd parity. For each completed frame it presents the byte, a parity-error flag and a framing-error flag, plus a one-cycle update strobe that the control block edge-detects. Bit timing (`rx_cnt`) and parity mode come from the control block's configuration register.

---
 rtl/uart_rx_core_pkg.sv | 12 +
 rtl/uart_rx_core_if.sv | 13 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_rx_core.sv | 97 +++++++++
 4 files changed

// File: rtl/uart_rx_core_pkg.sv
// uart_rx_core_pkg: shared state encodings, parity constants and parity check for the UART receiver
package uart_rx_core_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} rx_state_t;
  localparam logic [1:0] UART_PAR_NONE = 2'b00;
  localparam logic [1:0] UART_PAR_EVEN = 2'b10;
  localparam logic [1:0] UART_PAR_ODD = 2'b11;
  localparam int UART_OVERSAMPLE = 16;
  // Even mode expects the XOR over data and parity bit to be 0, odd mode expects 1.
  function automatic logic par_err(input logic [7:0] d, input logic p, input logic [1:0] mode);
    return mode[1] && ((^{d, p}) != mode[0]);
  endfunction
endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: configuration in, received character and status out
//   rx_cnt/parity : config from the control block
//   rxdata/parityerror/frameerror/rxdataupdate : per-frame result and update strobe
interface uart_rx_core_if;
  logic [8:0] rx_cnt;
  logic [1:0] parity;
  logic [7:0] rxdata;
  logic parityerror;
  logic frameerror;
  logic rxdataupdate;
  modport master(input rx_cnt, parity, output rxdata, parityerror, frameerror, rxdataupdate);
  modport slave(output rx_cnt, parity, input rxdata, parityerror, frameerror, rxdataupdate);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator
//   clr/en : clear and enable (counter held at 0 while disabled)
//   period : clocks per tick; tick pulses on the last count of each period
module uart_baud_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [8:0] period,
  output logic       tick
);
  logic [8:0] cnt;
  assign tick = en && cnt == period - 9'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || !en || tick) ? '0 : cnt + 9'd1;
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampled 8-bit UART deframer with optional parity
//   clk/rst : clock, async active-high reset
//   rxd     : asynchronous serial input, idle high
//   rx_if   : config in (rx_cnt, parity), result out (rxdata, errors, update strobe)
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd,
  uart_rx_core_if.master  rx_if
);
  rx_state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic rxd_s, rxd_s_d, fall, tick, samp, mid, pbit, upd, pe, fe;
  logic [8:0] cnt_q;
  logic [1:0] par_q;
  logic [3:0] sub;
  logic [2:0] idx;
  logic [7:0] shreg, data;
  assign rxd_s = sync[SYNC_STAGES-1];
  assign fall = state == S_IDLE && rxd_s_d && !rxd_s;
  assign samp = tick && sub == 4'(OVERSAMPLE - 1);
  assign mid = tick && sub == 4'(OVERSAMPLE / 2 - 1);
  assign rx_if.rxdata = data;
  assign rx_if.parityerror = pe;
  assign rx_if.frameerror = fe;
  assign rx_if.rxdataupdate = upd;
  uart_baud_tick u_tick (
    .clk(clk),
    .rst(rst),
    .clr(fall),
    .en(state != S_IDLE && state != S_BREAK),
    .period(cnt_q),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '1;
      rxd_s_d <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rxd};
      rxd_s_d <= rxd_s;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      cnt_q <= '0;
      par_q <= '0;
      sub <= '0;
      idx <= '0;
      shreg <= '0;
      pbit <= 1'b0;
      data <= '0;
      pe <= 1'b0;
      fe <= 1'b0;
      upd <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (tick) sub <= sub + 4'd1;
      case (state)
        S_IDLE: if (fall) begin
          state <= S_START;
          sub <= '0;
          cnt_q <= rx_if.rx_cnt < 9'd2 ? 9'd2 : rx_if.rx_cnt;
          par_q <= rx_if.parity;
        end
        S_START: if (mid) begin
          state <= rxd_s ? S_IDLE : S_DATA;
          sub <= '0;
          idx <= '0;
        end
        S_DATA: if (samp) begin
          shreg[idx] <= rxd_s;
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= par_q[1] ? S_PARITY : S_STOP;
        end
        S_PARITY: if (samp) begin
          pbit <= rxd_s;
          state <= S_STOP;
        end
        S_STOP: if (samp) begin
          data <= shreg;
          pe <= par_err(shreg, pbit, par_q);
          fe <= ~rxd_s;
          upd <= 1'b1;
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
          state <= rxd_s ? S_IDLE : S_BREAK;
        end
        S_BREAK: if (rxd_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule
